vram_port_arbiter: RTL and testbench

Shares the single-port vector RAM (CPU window 0x2000-0x3FFF) between two requesters: vector-generator (VG) reads and CPU writes drained from the store queue.
Sequences VG run/flush phases from the vggo/vgrst strobes. VG reads have priority while the VG runs, bounded by an anti-starvation slot for queued CPU writes.
Sits between the store queue's head/canWrite interface, the VG fetch unit and the vector BRAM port.

---
 rtl/vram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Arbitrates the single-port vector RAM between VG reads and store-queue CPU writes,
// and sequences the VG run/flush phases from the vggo/vgrst strobes.
module vram_port_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter logic [15:0] VRAM_BASE  = 16'h2000,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vggo,
  input  logic              vgrst,
  input  logic              vg_done,
  input  logic              vg_rd_req,
  input  logic [ADDR_W-1:0] vg_rd_addr,
  output logic              vg_rd_gnt,
  output logic              vg_rd_valid,
  output logic [7:0]        vg_rd_data,
  input  logic              sq_valid,
  input  logic [15:0]       sq_addr,
  input  logic [7:0]        sq_data,
  output logic              sq_pop,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              vg_running,
  output logic              drop_pulse
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [7:0]  StarveMax = 8'(STARVE_MAX);
  localparam logic [16:0] WinLo     = {1'b0, VRAM_BASE};
  localparam logic [16:0] WinHi     = WinLo + (17'd1 << ADDR_W);

  state_e            state_q;
  logic              go_pending_q;
  logic [7:0]        starve_cnt_q;
  logic              vg_rd_valid_q;
  logic              drop_pulse_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic              starved;
  logic              in_window;
  logic [ADDR_W-1:0] wr_offset;

  assign in_window = ({1'b0, sq_addr} >= WinLo) && ({1'b0, sq_addr} < WinHi);
  assign wr_offset = ADDR_W'(sq_addr - VRAM_BASE);
  assign starved   = sq_valid && (starve_cnt_q == StarveMax);

  // One RAM access per cycle; a grant and a pop are mutually exclusive by construction.
  always_comb begin
    vg_rd_gnt = 1'b0;
    sq_pop    = 1'b0;
    unique case (state_q)
      StRun: begin
        vg_rd_gnt = vg_rd_req && !starved;
        sq_pop    = sq_valid && !vg_rd_gnt;
      end
      StIdle: begin
        sq_pop    = sq_valid;
        vg_rd_gnt = vg_rd_req && !sq_valid;
      end
      default: sq_pop = sq_valid;
    endcase
  end

  always_comb begin
    ram_addr  = ram_addr_q;
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    if (sq_pop) begin
      ram_addr  = wr_offset;
      ram_wdata = sq_data;
      ram_we    = in_window;
    end else if (vg_rd_gnt) begin
      ram_addr = vg_rd_addr;
    end
  end

  assign vg_rd_valid = vg_rd_valid_q;
  assign vg_rd_data  = vg_rd_valid_q ? ram_rdata : 8'h00;
  assign drop_pulse  = drop_pulse_q;
  assign vg_running  = (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      go_pending_q  <= 1'b0;
      starve_cnt_q  <= 8'h00;
      vg_rd_valid_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      ram_addr_q    <= '0;
    end else begin
      ram_addr_q    <= ram_addr;
      vg_rd_valid_q <= vg_rd_gnt && !vgrst;
      drop_pulse_q  <= sq_pop && !in_window;

      if (vgrst || sq_pop || !sq_valid) begin
        starve_cnt_q <= 8'h00;
      end else if (vg_rd_gnt && (starve_cnt_q != StarveMax)) begin
        starve_cnt_q <= starve_cnt_q + 8'h01;
      end

      if (vgrst) begin
        state_q      <= StIdle;
        go_pending_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: if (vggo) state_q <= StRun;
          StRun: begin
            if (vg_done) state_q <= sq_valid ? StFlush : StIdle;
          end
          default: begin
            // A vggo seen while draining restarts the VG once the queue is empty.
            if (!sq_valid) begin
              state_q      <= (go_pending_q || vggo) ? StRun : StIdle;
              go_pending_q <= 1'b0;
            end else if (vggo) begin
              go_pending_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed vector table, hand-written phase sequences, and a
// randomized run checked against a rule-level model with a shadow copy of RAM contents.
module tb_vram_port_arbiter;

  localparam int          AW   = 13;
  localparam logic [15:0] BASE = 16'h2000;
  localparam int          SMAX = 8;
  localparam int          MIdle = 0, MRun = 1, MFlush = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vggo, vgrst, vg_done, vg_rd_req;
  logic [AW-1:0] vg_rd_addr;
  logic          vg_rd_gnt, vg_rd_valid;
  logic [7:0]    vg_rd_data;
  logic          sq_valid;
  logic [15:0]   sq_addr;
  logic [7:0]    sq_data;
  logic          sq_pop;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata = 8'h00;
  logic          vg_running, drop_pulse;
  logic          mem_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W    (AW),
    .VRAM_BASE (BASE),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vggo       (vggo),
    .vgrst      (vgrst),
    .vg_done    (vg_done),
    .vg_rd_req  (vg_rd_req),
    .vg_rd_addr (vg_rd_addr),
    .vg_rd_gnt  (vg_rd_gnt),
    .vg_rd_valid(vg_rd_valid),
    .vg_rd_data (vg_rd_data),
    .sq_valid   (sq_valid),
    .sq_addr    (sq_addr),
    .sq_data    (sq_data),
    .sq_pop     (sq_pop),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .vg_running (vg_running),
    .drop_pulse (drop_pulse)
  );

  // Single-port BRAM stub, one cycle read latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic go, input logic rs, input logic dn, input logic rq,
                       input logic [AW-1:0] ra, input logic sv, input logic [15:0] sa,
                       input logic [7:0] sd);
    @(negedge clk);
    vggo = go; vgrst = rs; vg_done = dn; vg_rd_req = rq; vg_rd_addr = ra;
    sq_valid = sv; sq_addr = sa; sq_data = sd;
    #1;
  endtask

  typedef struct {
    logic go, rs, dn, rq; logic [AW-1:0] ra; logic sv; logic [15:0] sa; logic [7:0] sd;
    logic gnt, pop, we; logic [AW-1:0] addr; logic [7:0] wdata;
    logic run, valid; logic [7:0] rdata; logic drop;
  } vec_t;

  vec_t tbl [8];

  // Random-phase model state
  int          m_mode, m_starve;
  logic        m_pend, m_rv, m_rv_known, m_drop, m_last_ok;
  logic [7:0]  m_rd;
  logic [AW-1:0] m_last;
  logic [7:0]  refm  [0:(1<<AW)-1];
  logic        known [0:(1<<AW)-1];

  initial begin
    logic e_gnt, e_pop, e_we, inwin, starved;
    logic [AW-1:0] e_addr, off;
    logic [15:0] diff;
    int run_len, max_run;

    rst_n = 1'b0; mem_clr = 1'b1;
    vggo = 0; vgrst = 0; vg_done = 0; vg_rd_req = 0; vg_rd_addr = '0;
    sq_valid = 0; sq_addr = '0; sq_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset vg_rd_valid", 32'(vg_rd_valid), 32'd0);
    chk("reset vg_rd_data", 32'(vg_rd_data), 32'd0);
    chk("reset drop_pulse", 32'(drop_pulse), 32'd0);
    chk("reset vg_running", 32'(vg_running), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;

    // Directed vectors: write, dropped write, IDLE read, vggo, RUN reads, vg_done -> IDLE.
    tbl[0] = '{0,0,0,0,13'h000,1,16'h2005,8'hA5, 0,1,1,13'h005,8'hA5, 0,0,8'h00,0};
    tbl[1] = '{0,0,0,0,13'h000,1,16'h4000,8'h77, 0,1,0,13'h000,8'h77, 0,0,8'h00,0};
    tbl[2] = '{0,0,0,1,13'h005,0,16'h0000,8'h00, 1,0,0,13'h005,8'h00, 0,0,8'h00,1};
    tbl[3] = '{1,0,0,0,13'h000,0,16'h0000,8'h00, 0,0,0,13'h005,8'h00, 0,1,8'hA5,0};
    tbl[4] = '{0,0,0,1,13'h005,0,16'h0000,8'h00, 1,0,0,13'h005,8'h00, 1,0,8'h00,0};
    tbl[5] = '{0,0,0,1,13'h005,0,16'h0000,8'h00, 1,0,0,13'h005,8'h00, 1,1,8'hA5,0};
    tbl[6] = '{0,0,1,0,13'h000,0,16'h0000,8'h00, 0,0,0,13'h005,8'h00, 1,1,8'hA5,0};
    tbl[7] = '{0,0,0,0,13'h000,0,16'h0000,8'h00, 0,0,0,13'h005,8'h00, 0,0,8'h00,0};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].go, tbl[i].rs, tbl[i].dn, tbl[i].rq, tbl[i].ra, tbl[i].sv, tbl[i].sa,
            tbl[i].sd);
      chk($sformatf("vec%0d vg_rd_gnt", i), 32'(vg_rd_gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d sq_pop", i), 32'(sq_pop), 32'(tbl[i].pop));
      chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].wdata));
      chk($sformatf("vec%0d vg_running", i), 32'(vg_running), 32'(tbl[i].run));
      chk($sformatf("vec%0d vg_rd_valid", i), 32'(vg_rd_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d vg_rd_data", i), 32'(vg_rd_data), 32'(tbl[i].rdata));
      chk($sformatf("vec%0d drop_pulse", i), 32'(drop_pulse), 32'(tbl[i].drop));
    end

    // Anti-starvation: SMAX VG grants then one pop, repeating.
    drive(1, 0, 0, 0, '0, 0, '0, '0);
    run_len = 0; max_run = 0;
    for (int i = 0; i < 3 * (SMAX + 1); i++) begin
      drive(0, 0, 0, 1, 13'h100, 1, 16'h2100, 8'h11);
      chk($sformatf("starve gnt c%0d", i), 32'(vg_rd_gnt), 32'((i % (SMAX + 1)) != SMAX));
      chk($sformatf("starve pop c%0d", i), 32'(sq_pop), 32'((i % (SMAX + 1)) == SMAX));
      run_len = vg_rd_gnt ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
    chk("starve max consecutive grants", 32'(max_run), 32'(SMAX));

    // vg_done with queued writes; vggo during FLUSH restarts the VG after draining.
    drive(0, 0, 1, 1, 13'h100, 1, 16'h2010, 8'h20);
    chk("flush entry gnt", 32'(vg_rd_gnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(logic'(k == 0), 0, 0, 1, 13'h100, 1, 16'(16'h2011 + k), 8'(8'h21 + k));
      chk($sformatf("flush%0d pop", k), 32'(sq_pop), 32'd1);
      chk($sformatf("flush%0d gnt", k), 32'(vg_rd_gnt), 32'd0);
      chk($sformatf("flush%0d we", k), 32'(ram_we), 32'd1);
      chk($sformatf("flush%0d running", k), 32'(vg_running), 32'd0);
    end
    drive(0, 0, 0, 1, 13'h100, 0, '0, '0);
    chk("flush empty gnt", 32'(vg_rd_gnt), 32'd0);
    drive(0, 0, 0, 1, 13'h100, 0, '0, '0);
    chk("flush restart running", 32'(vg_running), 32'd1);
    chk("flush restart gnt", 32'(vg_rd_gnt), 32'd1);

    // vgrst together with a grant squashes the returning read.
    drive(0, 1, 0, 1, 13'h100, 0, '0, '0);
    chk("vgrst same-cycle gnt", 32'(vg_rd_gnt), 32'd1);
    drive(0, 0, 0, 0, '0, 0, '0, '0);
    chk("vgrst running", 32'(vg_running), 32'd0);
    chk("vgrst valid", 32'(vg_rd_valid), 32'd0);

    // Async reset mid-RUN with a read in flight.
    drive(1, 0, 0, 0, '0, 0, '0, '0);
    drive(0, 0, 0, 1, 13'h005, 0, '0, '0);
    chk("pre-reset gnt", 32'(vg_rd_gnt), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0; vg_rd_req = 1'b0;
    #1;
    chk("async reset valid", 32'(vg_rd_valid), 32'd0);
    chk("async reset data", 32'(vg_rd_data), 32'd0);
    chk("async reset running", 32'(vg_running), 32'd0);
    chk("async reset drop", 32'(drop_pulse), 32'd0);
    chk("async reset we", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the rule-level model.
    m_mode = MIdle; m_starve = 0; m_pend = 0; m_rv = 0; m_rv_known = 0; m_drop = 0;
    m_rd = '0; m_last = '0; m_last_ok = 0;
    for (int i = 0; i < (1 << AW); i++) begin refm[i] = 8'h00; known[i] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      vggo = ($urandom_range(0, 9) == 0);
      vgrst = ($urandom_range(0, 49) == 0);
      vg_done = ($urandom_range(0, 11) == 0);
      vg_rd_req = ($urandom_range(0, 9) < 6);
      vg_rd_addr = AW'($urandom_range(0, 15));
      sq_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r < 7) sq_addr = 16'(BASE + 16'($urandom_range(0, 15)));
      else if (r == 7) sq_addr = 16'($urandom_range(0, 16'h1FFF));
      else sq_addr = 16'(16'h4000 + 16'($urandom_range(0, 16'hBFFF)));
      sq_data = 8'($urandom);
      #1;
      starved = (m_mode == MRun) && sq_valid && (m_starve == SMAX);
      e_gnt = vg_rd_req && (((m_mode == MRun) && !starved) || ((m_mode == MIdle) && !sq_valid));
      e_pop = sq_valid && !e_gnt;
      inwin = (int'(sq_addr) >= int'(BASE)) && (int'(sq_addr) < int'(BASE) + (1 << AW));
      e_we = e_pop && inwin;
      diff = sq_addr - BASE;
      off = diff[AW-1:0];
      e_addr = e_pop ? off : (e_gnt ? vg_rd_addr : m_last);
      chk("rand vg_rd_gnt", 32'(vg_rd_gnt), 32'(e_gnt));
      chk("rand sq_pop", 32'(sq_pop), 32'(e_pop));
      chk("rand ram_we", 32'(ram_we), 32'(e_we));
      chk("rand ram_wdata", 32'(ram_wdata), e_pop ? 32'(sq_data) : 32'd0);
      if (e_pop || e_gnt || m_last_ok) chk("rand ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("rand vg_running", 32'(vg_running), 32'(m_mode == MRun));
      chk("rand vg_rd_valid", 32'(vg_rd_valid), 32'(m_rv));
      chk("rand drop_pulse", 32'(drop_pulse), 32'(m_drop));
      if (!m_rv) chk("rand vg_rd_data idle", 32'(vg_rd_data), 32'd0);
      else if (m_rv_known) chk("rand vg_rd_data", 32'(vg_rd_data), 32'(m_rd));

      m_rv = e_gnt && !vgrst;
      m_rv_known = known[vg_rd_addr];
      m_rd = refm[vg_rd_addr];
      m_drop = e_pop && !inwin;
      if (e_we) begin refm[off] = sq_data; known[off] = 1'b1; end
      if (e_pop || e_gnt) begin m_last = e_addr; m_last_ok = 1'b1; end
      if (vgrst || e_pop || !sq_valid) m_starve = 0;
      else if (e_gnt && m_starve < SMAX) m_starve++;
      if (vgrst) begin
        m_mode = MIdle; m_pend = 0;
      end else if (m_mode == MIdle) begin
        if (vggo) m_mode = MRun;
      end else if (m_mode == MRun) begin
        if (vg_done) m_mode = sq_valid ? MFlush : MIdle;
      end else begin
        if (!sq_valid) begin
          m_mode = (m_pend || vggo) ? MRun : MIdle;
          m_pend = 0;
        end else if (vggo) begin
          m_pend = 1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
